// File: rtl/fifo_traffic_monitor.sv
// Traffic monitor for NUM_CH FIFOs: tracks occupancy, peak occupancy and
// per-run write/read counts, with a register slave and an IDLE/RUN/DONE program.
module fifo_traffic_monitor #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       slave_addr,
    input  logic              slave_rd,
    input  logic              slave_wr,
    input  logic [31:0]       slave_data_in,
    output logic [31:0]       slave_data_out,
    input  logic [NUM_CH-1:0] ch_wr,
    input  logic [NUM_CH-1:0] ch_rd,
    output logic              active_program,
    output logic              end_program,
    output logic              flag_irq
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cycle_cnt, cycle_limit;
    logic [CNT_W-1:0]  wr_cnt  [NUM_CH];
    logic [CNT_W-1:0]  rd_cnt  [NUM_CH];
    logic [OCC_W-1:0]  occ     [NUM_CH];
    logic [OCC_W-1:0]  max_occ [NUM_CH];
    logic [OCC_W-1:0]  occ_nxt [NUM_CH];
    logic [NUM_CH-1:0] ovf_flags, unf_flags, ovf_set, unf_set, ovf_nxt, unf_nxt;
    logic [31:0]       status, rdata;
    logic              unused_bits;

    wire [5:0] reg_idx  = slave_addr[7:2];
    wire       ctrl_wr  = slave_wr && (reg_idx == 6'd0);
    wire       start    = ctrl_wr && slave_data_in[0];
    wire       stop     = ctrl_wr && slave_data_in[1];
    wire       clear    = ctrl_wr && slave_data_in[2];
    wire       flag_clr = ctrl_wr && slave_data_in[3];
    wire       limit_wr = slave_wr && (reg_idx == 6'd2);
    wire       go       = (state == IDLE) && start;
    // Extra bit keeps the compare honest once cycle_cnt has saturated.
    wire       limit_hit = (cycle_limit != '0) &&
                           (({1'b0, cycle_cnt} + 1'b1) == {1'b0, cycle_limit});

    assign unused_bits = ^{slave_addr[31:8], slave_addr[1:0], slave_data_in};

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (stop || limit_hit) next_state = DONE;
            DONE:    if (clear) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            occ_nxt[i] = occ[i];
            ovf_set[i] = 1'b0;
            unf_set[i] = 1'b0;
            if (ch_wr[i] && !ch_rd[i]) begin
                if (occ[i] == OCC_FULL) ovf_set[i] = 1'b1;
                else                    occ_nxt[i] = occ[i] + 1'b1;
            end else if (ch_rd[i] && !ch_wr[i]) begin
                if (occ[i] == '0) unf_set[i] = 1'b1;
                else              occ_nxt[i] = occ[i] - 1'b1;
            end
        end
        ovf_nxt = (flag_clr ? '0 : ovf_flags) | ovf_set;
        unf_nxt = (flag_clr ? '0 : unf_flags) | unf_set;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            active_program <= 1'b0;
            end_program    <= 1'b0;
            flag_irq       <= 1'b0;
            ovf_flags      <= '0;
            unf_flags      <= '0;
            cycle_limit    <= '0;
        end else begin
            state          <= next_state;
            active_program <= (next_state == RUN);
            end_program    <= (state == RUN) && (next_state == DONE);
            flag_irq       <= |{ovf_nxt, unf_nxt};
            ovf_flags      <= ovf_nxt;
            unf_flags      <= unf_nxt;
            if (limit_wr) cycle_limit <= slave_data_in[CNT_W-1:0];
        end
    end

    // NOTE: the per-channel arrays are plain flops, not RAM, so they reset with everything else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_cnt[i]  <= '0;
                rd_cnt[i]  <= '0;
                occ[i]     <= '0;
                max_occ[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) occ[i] <= occ_nxt[i];
            if (go) begin
                cycle_cnt <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    wr_cnt[i]  <= '0;
                    rd_cnt[i]  <= '0;
                    max_occ[i] <= '0;
                end
            end else if (state == RUN) begin
                if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_wr[i] && wr_cnt[i] != '1) wr_cnt[i] <= wr_cnt[i] + 1'b1;
                    if (ch_rd[i] && rd_cnt[i] != '1) rd_cnt[i] <= rd_cnt[i] + 1'b1;
                    if (occ_nxt[i] > max_occ[i]) max_occ[i] <= occ_nxt[i];
                end
            end
        end
    end

    always_comb begin
        status = '0;
        status[1:0] = state;
        status[8 +: NUM_CH]  = ovf_flags;
        status[16 +: NUM_CH] = unf_flags;

        rdata = '0;
        case (reg_idx)
            6'd1: rdata = status;
            6'd2: rdata = 32'(cycle_limit);
            6'd3: rdata = 32'(cycle_cnt);
            default: begin
                // Channel i occupies word indices 4*(i+1) .. 4*(i+1)+3.
                for (int i = 0; i < NUM_CH; i++) begin
                    if (reg_idx[5:2] == 4'(i + 1)) begin
                        case (reg_idx[1:0])
                            2'd0: rdata = 32'(wr_cnt[i]);
                            2'd1: rdata = 32'(rd_cnt[i]);
                            2'd2: rdata = 32'(occ[i]);
                            default: rdata = 32'(max_occ[i]);
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        slave_data_out <= '0;
        else if (slave_rd) slave_data_out <= rdata;
    end

endmodule

// File: tb/tb_fifo_traffic_monitor.sv
// Directed bench for fifo_traffic_monitor: a default-sized instance plus a
// small one (CNT_W=8, FIFO_DEPTH=4) for saturation and overflow corners.
module tb_fifo_traffic_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [3:0]  chw_a, chr_a, chw_b, chr_b;
    logic [31:0] dout_a, dout_b;
    logic        act_a, end_a, irq_a, act_b, end_b, irq_b;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fifo_traffic_monitor dut_a (
        .clk(clk), .reset(reset),
        .slave_addr(addr), .slave_rd(rd_a), .slave_wr(wr_a),
        .slave_data_in(wdata), .slave_data_out(dout_a),
        .ch_wr(chw_a), .ch_rd(chr_a),
        .active_program(act_a), .end_program(end_a), .flag_irq(irq_a)
    );

    fifo_traffic_monitor #(.NUM_CH(4), .CNT_W(8), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset),
        .slave_addr(addr), .slave_rd(rd_b), .slave_wr(wr_b),
        .slave_data_in(wdata), .slave_data_out(dout_b),
        .ch_wr(chw_b), .ch_rd(chr_b),
        .active_program(act_b), .end_program(end_b), .flag_irq(irq_b)
    );

    task automatic bus_wr(input bit b, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d;
        if (b) wr_b = 1'b1; else wr_a = 1'b1;
        @(negedge clk);
        wr_a = 1'b0; wr_b = 1'b0;
    endtask

    task automatic bus_rd(input bit b, input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        if (b) rd_b = 1'b1; else rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0; rd_b = 1'b0;
        d = b ? dout_b : dout_a;
    endtask

    task automatic pulse_ch(input bit b, input logic [3:0] w, input logic [3:0] r, input int n);
        @(negedge clk);
        if (b) begin chw_b = w; chr_b = r; end
        else   begin chw_a = w; chr_a = r; end
        repeat (n) @(negedge clk);
        chw_a = '0; chr_a = '0; chw_b = '0; chr_b = '0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0;
        addr = '0; wdata = '0;
        rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
        chw_a = '0; chr_a = '0; chw_b = '0; chr_b = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({act_a, end_a, irq_a, dout_a} !== 35'd0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {act_a, end_a, irq_a, dout_a});
        end
        reset = 1'b1;
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 0", d); end
        bus_rd(0, 32'h08, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reset_limit: got %h expected 0", d); end
    endtask

    task automatic test_cycle_limit;
        logic [31:0] d;
        int na = 0, ne = 0;
        bus_wr(0, 32'h08, 32'd10);
        bus_wr(0, 32'h00, 32'h1);
        for (int k = 0; k < 30; k++) begin
            if (act_a) na++;
            if (end_a) ne++;
            @(negedge clk);
        end
        n_vec++;
        if (na !== 10) begin n_err++; $display("FAIL active_cycles: got %0d expected 10", na); end
        n_vec++;
        if (ne !== 1) begin n_err++; $display("FAIL end_pulses: got %0d expected 1", ne); end
        bus_rd(0, 32'h0C, d);
        n_vec++;
        if (d !== 32'd10) begin n_err++; $display("FAIL cycle_cnt_limit: got %0d expected 10", d); end
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h2) begin n_err++; $display("FAIL status_done: got %h expected 2", d); end
        bus_wr(0, 32'h00, 32'h1);
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h2) begin n_err++; $display("FAIL start_in_done: got %h expected 2", d); end
        bus_wr(0, 32'h00, 32'h4);
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL clear_to_idle: got %h expected 0", d); end
    endtask

    task automatic test_traffic;
        logic [31:0] d;
        bus_wr(0, 32'h08, 32'd0);
        bus_wr(0, 32'h00, 32'h3);
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h1) begin n_err++; $display("FAIL start_stop_same: got %h expected 1", d); end
        pulse_ch(0, 4'b0100, 4'b0000, 5);
        pulse_ch(0, 4'b0000, 4'b0100, 3);
        pulse_ch(0, 4'b0100, 4'b0100, 1);
        bus_rd(0, 32'h30, d);
        n_vec++;
        if (d !== 32'd6) begin n_err++; $display("FAIL wr_cnt2: got %0d expected 6", d); end
        bus_rd(0, 32'h34, d);
        n_vec++;
        if (d !== 32'd4) begin n_err++; $display("FAIL rd_cnt2: got %0d expected 4", d); end
        bus_rd(0, 32'h38, d);
        n_vec++;
        if (d !== 32'd2) begin n_err++; $display("FAIL occ2: got %0d expected 2", d); end
        bus_rd(0, 32'h3C, d);
        n_vec++;
        if (d !== 32'd5) begin n_err++; $display("FAIL max_occ2: got %0d expected 5", d); end
        bus_rd(0, 32'hABCD_EF3B, d);
        n_vec++;
        if (d !== 32'd2) begin n_err++; $display("FAIL addr_alias: got %0d expected 2", d); end
        bus_wr(0, 32'h30, 32'hFFFF);
        bus_rd(0, 32'h30, d);
        n_vec++;
        if (d !== 32'd6) begin n_err++; $display("FAIL ro_write: got %0d expected 6", d); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (dout_a !== 32'd6) begin n_err++; $display("FAIL data_hold: got %0d expected 6", dout_a); end
        bus_rd(0, 32'h50, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL absent_channel: got %h expected 0", d); end
        bus_rd(0, 32'h00, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_read: got %h expected 0", d); end
        bus_wr(0, 32'h00, 32'h2);
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h2) begin n_err++; $display("FAIL stop_to_done: got %h expected 2", d); end
        bus_wr(0, 32'h00, 32'h4);
    endtask

    task automatic test_underflow;
        logic [31:0] d;
        pulse_ch(0, 4'b0000, 4'b0001, 1);
        n_vec++;
        if (irq_a !== 1'b1) begin n_err++; $display("FAIL irq_underflow: got %b expected 1", irq_a); end
        bus_rd(0, 32'h18, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL occ0_floor: got %0d expected 0", d); end
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h0001_0000) begin n_err++; $display("FAIL status_unf0: got %h expected 00010000", d); end
        bus_wr(0, 32'h00, 32'h8);
        n_vec++;
        if (irq_a !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b expected 0", irq_a); end
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL status_cleared: got %h expected 0", d); end
        @(negedge clk);
        addr = 32'h0; wdata = 32'h8; wr_a = 1'b1; chr_a = 4'b0001;
        @(negedge clk);
        wr_a = 1'b0; chr_a = '0;
        bus_rd(0, 32'h04, d);
        n_vec++;
        if (d !== 32'h0001_0000) begin n_err++; $display("FAIL set_beats_clear: got %h expected 00010000", d); end
        bus_wr(0, 32'h00, 32'h8);
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        pulse_ch(1, 4'b0010, 4'b0000, 6);
        bus_rd(1, 32'h28, d);
        n_vec++;
        if (d !== 32'd4) begin n_err++; $display("FAIL occ1_ceiling: got %0d expected 4", d); end
        bus_rd(1, 32'h04, d);
        n_vec++;
        if (d !== 32'h0000_0200) begin n_err++; $display("FAIL status_ovf1: got %h expected 00000200", d); end
        n_vec++;
        if (irq_b !== 1'b1) begin n_err++; $display("FAIL irq_overflow: got %b expected 1", irq_b); end
        bus_rd(1, 32'h2C, d);
        n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL max_occ_idle: got %0d expected 0", d); end
        pulse_ch(1, 4'b0000, 4'b0010, 1);
        bus_rd(1, 32'h28, d);
        n_vec++;
        if (d !== 32'd3) begin n_err++; $display("FAIL occ1_drain: got %0d expected 3", d); end
        bus_wr(1, 32'h00, 32'h8);
    endtask

    task automatic test_saturation;
        logic [31:0] d;
        bus_wr(1, 32'h00, 32'h1);
        repeat (300) @(negedge clk);
        bus_rd(1, 32'h0C, d);
        n_vec++;
        if (d !== 32'd255) begin n_err++; $display("FAIL cycle_cnt_sat: got %0d expected 255", d); end
        bus_rd(1, 32'h04, d);
        n_vec++;
        if (d !== 32'h1) begin n_err++; $display("FAIL still_running: got %h expected 1", d); end
        bus_wr(1, 32'h00, 32'h2);
        bus_rd(1, 32'h04, d);
        n_vec++;
        if (d !== 32'h2) begin n_err++; $display("FAIL sat_stop: got %h expected 2", d); end
        bus_wr(1, 32'h00, 32'h4);
        bus_rd(1, 32'h04, d);
        n_vec++;
        if (d !== 32'h0) begin n_err++; $display("FAIL sat_clear: got %h expected 0", d); end
        bus_wr(1, 32'h08, 32'h1FF);
        bus_rd(1, 32'h08, d);
        n_vec++;
        if (d !== 32'hFF) begin n_err++; $display("FAIL limit_width: got %h expected ff", d); end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] d;
        int ne = 0, na = 0;
        bus_wr(0, 32'h08, 32'd50);
        bus_wr(0, 32'h00, 32'h1);
        pulse_ch(0, 4'b1000, 4'b0000, 2);
        repeat (5) @(negedge clk);
        bus_rd(0, 32'h48, d);
        n_vec++;
        if (d !== 32'd2) begin n_err++; $display("FAIL occ3_pre_reset: got %0d expected 2", d); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({act_a, end_a, dout_a} !== 34'd0) begin
            n_err++; $display("FAIL async_reset: got %h expected 0", {act_a, end_a, dout_a});
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (end_a) ne++;
            if (act_a) na++;
            @(negedge clk);
        end
        n_vec++;
        if (ne + na !== 0) begin n_err++; $display("FAIL post_reset_quiet: got %0d expected 0", ne + na); end
        for (int k = 0; k < 6; k++) begin
            logic [31:0] a;
            case (k)
                0: a = 32'h04;
                1: a = 32'h08;
                2: a = 32'h0C;
                3: a = 32'h40;
                4: a = 32'h48;
                default: a = 32'h3C;
            endcase
            bus_rd(0, a, d);
            n_vec++;
            if (d !== 32'h0) begin n_err++; $display("FAIL reg_after_reset @%h: got %h expected 0", a, d); end
        end
    endtask

    initial begin
        test_reset;
        test_cycle_limit;
        test_traffic;
        test_underflow;
        test_overflow;
        test_saturation;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
